// File: rtl/obi_wb_pkg.sv
// Shared types and helpers for the OBI to Wishbone pipelined bridge.
package obi_wb_pkg;

    typedef enum logic {
        RSP_OK  = 1'b0,
        RSP_ERR = 1'b1
    } rsp_e;

    // Byte-to-word address shift for a given data width.
    function automatic int unsigned word_shift(input int unsigned data_w);
        return $unsigned($clog2(data_w / 8));
    endfunction

    // True when addr maps into the Wishbone word window that starts at base.
    function automatic logic addr_window_check(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned shift,
        input int unsigned wb_addr_w
    );
        logic [63:0] word;
        word = (addr - base) >> shift;
        return (addr >= base) && ((word >> wb_addr_w) == 64'd0);
    endfunction

endpackage

// File: rtl/obi_wb_tag_fifo.sv
// Small synchronous FIFO carrying per-transfer tags in issue order.
module obi_wb_tag_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!push_i && pop_i) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/obi_wb_pipe_bridge.sv
// OBI slave to Wishbone B4 pipelined master bridge with several transfers in flight.
// Define OBI_WB_TIMEOUT_EN to abort a slave that stops answering after TIMEOUT_CYCLES.
module obi_wb_pipe_bridge #(
    parameter int unsigned            ADDR_W         = 32,
    parameter int unsigned            DATA_W         = 32,
    parameter int unsigned            WB_ADDR_W      = 20,
    parameter logic [ADDR_W-1:0]      ADDR_BASE      = '0,
    parameter int unsigned            MAX_OUTST      = 2,
    parameter int unsigned            TIMEOUT_CYCLES = 255
) (
    input  logic                  obi_clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  obi_req_i,
    input  logic                  obi_we_i,
    input  logic [ADDR_W-1:0]     obi_addr_i,
    input  logic [DATA_W/8-1:0]   obi_be_i,
    input  logic [DATA_W-1:0]     obi_wdata_i,
    output logic                  obi_gnt_o,
    output logic                  obi_rvalid_o,
    output logic                  obi_err_o,
    output logic [DATA_W-1:0]     obi_rdata_o,
    output logic [WB_ADDR_W-1:0]  wb_adr_o,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic [DATA_W/8-1:0]   wb_sel_o,
    output logic                  wb_we_o,
    output logic                  wb_stb_o,
    output logic                  wb_cyc_o,
    input  logic [DATA_W-1:0]     wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_stall_i,
    output logic                  busy_o
);
    import obi_wb_pkg::*;

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned SHIFT = word_shift(DATA_W);
    localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);

    logic [OUT_W-1:0]     outst_q, outst_d;
    logic                 stb_q, stb_d, cyc_q, cyc_d, we_q, we_d;
    logic [WB_ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0]    dat_q, dat_d;
    logic [BE_W-1:0]      sel_q, sel_d;
    logic                 rvalid_q, rvalid_d, busy_q, busy_d;
    rsp_e                 rsp_q, rsp_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic                 in_win_c, open_c, acc_win_c, acc_oow_c;
    logic                 resp_c, dec_c, push_c, pop_c;
    logic [ADDR_W-1:0]    off_c;
    logic                 draining_c, to_hit_c;
    logic                 tag_we, tag_full, tag_empty;

    // Address decode and grant; local errors are answered on the very next
    // edge, so none is ever still pending when a new grant is decided.
    assign in_win_c  = addr_window_check(64'(obi_addr_i), 64'(ADDR_BASE), SHIFT, WB_ADDR_W);
    assign off_c     = obi_addr_i - ADDR_BASE;
    assign open_c    = obi_req_i & en_i & ~(stb_q & wb_stall_i) & ~draining_c & ~to_hit_c;
    assign obi_gnt_o = open_c & (in_win_c ? (outst_q < OUT_W'(MAX_OUTST)) : (outst_q == '0));
    assign acc_win_c = obi_gnt_o & in_win_c;
    assign acc_oow_c = obi_gnt_o & ~in_win_c;

    assign resp_c = (wb_ack_i | wb_err_i) & (outst_q != '0) & ~draining_c;
    assign dec_c  = resp_c | draining_c;
    assign push_c = acc_win_c & ~tag_full;
    assign pop_c  = dec_c & ~tag_empty;

    obi_wb_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (1)
    ) u_tag_fifo (
        .clk_i   (obi_clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_c),
        .wdata_i (obi_we_i),
        .pop_i   (pop_c),
        .rdata_o (tag_we),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

`ifdef OBI_WB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            drain_q, drain_d;

    assign draining_c = drain_q;
    assign to_hit_c   = ~drain_q & ~resp_c & (outst_q != '0) &
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    // Watchdog: count silent cycles, then flush every outstanding transfer as an error.
    always_comb begin
        to_cnt_d = to_cnt_q;
        drain_d  = drain_q;
        if ((outst_q == '0) || resp_c || to_hit_c) begin
            to_cnt_d = '0;
        end else if (!drain_q) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        if (to_hit_c) begin
            drain_d = 1'b1;
        end else if (drain_q && (outst_d == '0)) begin
            drain_d = 1'b0;
        end
    end

    // Watchdog state.
    always_ff @(posedge obi_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
            drain_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            drain_q  <= drain_d;
        end
    end
`else
    logic unused_timeout_c;

    assign draining_c       = 1'b0;
    assign to_hit_c         = 1'b0;
    assign unused_timeout_c = ^32'(TIMEOUT_CYCLES);
`endif

    // Next-state for issue register, in-flight count and response register.
    always_comb begin
        outst_d  = outst_q;
        stb_d    = stb_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        rvalid_d = 1'b0;
        rsp_d    = RSP_OK;
        rdata_d  = '0;

        if (acc_win_c && !dec_c) begin
            outst_d = outst_q + OUT_W'(1);
        end else if (!acc_win_c && dec_c) begin
            outst_d = outst_q - OUT_W'(1);
        end

        if (acc_win_c) begin
            stb_d = 1'b1;
            adr_d = WB_ADDR_W'(off_c >> SHIFT);
            dat_d = obi_wdata_i;
            sel_d = obi_be_i;
            we_d  = obi_we_i;
        end else if (stb_q && !wb_stall_i) begin
            stb_d = 1'b0;
        end
        if (to_hit_c || draining_c) begin
            stb_d = 1'b0;
        end

        if (resp_c) begin
            rvalid_d = 1'b1;
            if (wb_err_i) begin
                rsp_d = RSP_ERR;
            end else if (!tag_we) begin
                rdata_d = wb_dat_i;
            end
        end else if (draining_c || acc_oow_c) begin
            rvalid_d = 1'b1;
            rsp_d    = RSP_ERR;
        end

        cyc_d  = (outst_d != '0) & ~to_hit_c & ~draining_c;
        busy_d = (outst_d != '0) | rvalid_d;
    end

    // Registered state and outputs.
    always_ff @(posedge obi_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q  <= '0;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            rvalid_q <= 1'b0;
            rsp_q    <= RSP_OK;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            outst_q  <= outst_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            rvalid_q <= rvalid_d;
            rsp_q    <= rsp_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
        end
    end

    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign wb_we_o      = we_q;
    assign wb_stb_o     = stb_q;
    assign wb_cyc_o     = cyc_q;
    assign obi_rvalid_o = rvalid_q;
    assign obi_err_o    = (rsp_q == RSP_ERR);
    assign obi_rdata_o  = rdata_q;
    assign busy_o       = busy_q;

endmodule
